// File: rtl/div.sv
// div: multi-cycle 32-bit restoring divider, signed or unsigned.
//
// A division is accepted from the idle state while start_i is high and annul_i is low.
// The dividend and divisor are captured on that edge as magnitudes. One quotient bit is
// then produced per edge, MSB first, and signs are fixed up at the end. The result is held
// with ready_o high until start_i drops.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = two's-complement operands, 0 = unsigned
//   opdata1_i     dividend, sampled on the accepting edge only
//   opdata2_i     divisor, sampled on the accepting edge only
//   start_i       level request, held until ready_o is seen
//   annul_i       pipeline-flush cancel; effective while idle or iterating
//   result_o      {remainder, quotient}, zero unless ready_o
//   ready_o       result_o is valid
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;   // dividend bits shift out as quotient bits shift in
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;

    logic        op1_neg, op2_neg;
    logic [31:0] op1_mag, op2_mag;
    logic [32:0] trial, diff;
    logic        fits;

    assign op1_neg = signed_div_i & opdata1_i[31];
    assign op2_neg = signed_div_i & opdata2_i[31];
    assign op1_mag = op1_neg ? (32'd0 - opdata1_i) : opdata1_i;
    assign op2_mag = op2_neg ? (32'd0 - opdata2_i) : opdata2_i;

    // Partial remainder is always below the divisor, so the shifted trial is below twice
    // the divisor and bit 32 of the difference is exactly the borrow.
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, dvs_q};
    assign fits  = ~diff[32];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFree;
            cnt_q     <= 6'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFree: begin
                if (start_i && !annul_i) begin
                    state_d = (opdata2_i == 32'd0) ? StByZero : StOn;
                end
            end
            StByZero: state_d = StEnd;
            StOn: begin
                if (annul_i) begin
                    state_d = StFree;
                end else if (cnt_q == 6'd32) begin
                    state_d = StEnd;
                end
            end
            StEnd: begin
                if (!start_i) begin
                    state_d = StFree;
                end
            end
            default: state_d = StFree;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        unique case (state_q)
            StFree: begin
                result_d = 64'd0;
                if (start_i && !annul_i && (opdata2_i != 32'd0)) begin
                    quo_d     = op1_mag;
                    rem_d     = 32'd0;
                    dvs_d     = op2_mag;
                    cnt_d     = 6'd0;
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                end
            end
            StByZero: result_d = 64'd0;
            StOn: begin
                if (annul_i) begin
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                end else if (cnt_q == 6'd32) begin
                    result_d = {neg_rem_q ? (32'd0 - rem_q) : rem_q,
                                neg_quo_q ? (32'd0 - quo_q) : quo_q};
                end else begin
                    rem_d = fits ? diff[31:0] : trial[31:0];
                    quo_d = {quo_q[30:0], fits};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StEnd: begin
                if (!start_i) begin
                    result_d = 64'd0;
                end
            end
            default: result_d = 64'd0;
        endcase
    end

    // Outputs
    always_comb begin
        ready_o  = (state_q == StEnd);
        result_o = ready_o ? result_q : 64'd0;
    end

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero, remainder takes the
    // dividend's sign. A zero divisor gives zero.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Edge n=1 is the accepting edge; lat is the edge after which ready_o is first seen.
    // Operands are scrambled after acceptance. start_i is left high.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat);
        int n;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        n   = 0;
        lat = -1;
        res = 64'd0;
        while (n < 100) begin
            @(posedge clk);
            n = n + 1;
            @(negedge clk);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = $urandom_range(0, 1);
            if (ready_o) begin
                lat = n;
                res = result_o;
                break;
            end
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd100; opdata2_i = 32'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b result=%h, need ready=0 result=0",
                     ready_o, result_o);
        end
        start_i = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL idle_free: ready=%b result=%h, need 0/0", ready_o, result_o);
        end
        // Annul while idle blocks acceptance
        start_i = 1'b1; annul_i = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_annul: ready=%b, need 0", ready_o);
        end
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] da [4] = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
        logic [31:0] db [4] = '{32'd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic        ds [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [63:0] dx [4] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                                64'h00000000_80000000, 64'h80000000_00000000};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_div(ds[i], da[i], db[i], res, lat);
            checks++;
            if (lat !== 34) begin
                errors++;
                $display("FAIL directed_lat[%0d]: got %0d edges, need 34", i, lat);
            end
            checks++;
            if (res !== dx[i]) begin
                errors++;
                $display("FAIL directed_res[%0d]: got %h, need %h", i, res, dx[i]);
            end
            checks++;
            if (res !== model(ds[i], da[i], db[i])) begin
                errors++;
                $display("FAIL directed_model[%0d]: got %h, need %h", i, res,
                         model(ds[i], da[i], db[i]));
            end
            release_start();
        end
    endtask

    task automatic test_byzero();
        logic [63:0] res;
        int lat;
        int bad;
        do_div(1'b0, 32'd5, 32'd0, res, lat);
        checks++;
        if (lat !== 2 || res !== 64'd0) begin
            errors++;
            $display("FAIL byzero: lat=%0d res=%h, need lat=2 res=0", lat, res);
        end
        // Hold in END with start high; annul has no effect there
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            annul_i = (i == 1);
            @(posedge clk);
            @(negedge clk);
            if (ready_o !== 1'b1 || result_o !== 64'd0) bad++;
        end
        annul_i = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL byzero_hold: %0d bad cycles, need 0", bad);
        end
        release_start();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL byzero_release: ready=%b result=%h, need 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        int seen;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);                    // accepting edge
        repeat (9) @(posedge clk);         // ON edges 1..9
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);                    // 10th ON edge
        @(negedge clk);
        annul_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL annul_now: ready=%b result=%h, need 0/0", ready_o, result_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL annul_no_result: ready seen %0d cycles, need 0", seen);
        end
        do_div(1'b0, 32'd9, 32'd3, res, lat);
        checks++;
        if (lat !== 34 || res !== 64'h00000000_00000003) begin
            errors++;
            $display("FAIL annul_after: lat=%0d res=%h, need 34 / 0000000000000003",
                     lat, res);
        end
        release_start();
    endtask

    task automatic test_rst_mid();
        logic [63:0] res;
        int lat;
        @(negedge clk);
        signed_div_i = 1'b1; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd77;
        start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);                    // 20th ON edge
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid: ready=%b result=%h, need 0/0", ready_o, result_o);
        end
        rst = 1'b0; start_i = 1'b0;
        do_div(1'b0, 32'hFFFFFFFF, 32'h10, res, lat);
        checks++;
        if (lat !== 34 || res !== 64'h0000000F_0FFFFFFF) begin
            errors++;
            $display("FAIL rst_after: lat=%0d res=%h, need 34 / 0000000F0FFFFFFF", lat, res);
        end
        release_start();
    endtask

    task automatic test_random();
        logic [63:0] res, exp;
        logic [31:0] a, b;
        logic        sgn;
        int lat;
        for (int i = 0; i < 40; i++) begin
            sgn = $urandom_range(0, 1);
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(1, 20);
                1: b = 32'd0 - $urandom_range(1, 20);
                2: b = $urandom_range(0, 1) ? 32'd0 : 32'd1;
                default: b = $urandom;
            endcase
            exp = model(sgn, a, b);
            do_div(sgn, a, b, res, lat);
            checks++;
            if (res !== exp || lat !== ((b == 32'd0) ? 2 : 34)) begin
                errors++;
                $display("FAIL random[%0d] s=%b %h/%h: res=%h lat=%0d, need res=%h", i, sgn,
                         a, b, res, lat, exp);
            end
            release_start();
        end
    endtask

    // Release then immediately request again: one FREE cycle between operations
    task automatic test_back_to_back();
        logic [63:0] res;
        int lat;
        do_div(1'b1, 32'hFFFFFF9C, 32'd7, res, lat);
        checks++;
        if (res !== model(1'b1, 32'hFFFFFF9C, 32'd7) || lat !== 34) begin
            errors++;
            $display("FAIL b2b_first: res=%h lat=%0d, need %h / 34", res, lat,
                     model(1'b1, 32'hFFFFFF9C, 32'd7));
        end
        release_start();
        do_div(1'b1, 32'd1234567, 32'hFFFFFFF0, res, lat);
        checks++;
        if (res !== model(1'b1, 32'd1234567, 32'hFFFFFFF0) || lat !== 34) begin
            errors++;
            $display("FAIL b2b_second: res=%h lat=%0d, need %h / 34", res, lat,
                     model(1'b1, 32'd1234567, 32'hFFFFFFF0));
        end
        release_start();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_byzero();
        test_annul();
        test_rst_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 signed_div_i  input  1  1 = operands are two's-complement signed; 0 = unsigned.
REQ-005 opdata1_i  input  32  dividend; SHALL be sampled only on the accepting edge.
REQ-006 opdata2_i  input  32  divisor; SHALL be sampled only on the accepting edge.
REQ-007 start_i  input  1  level request; held high by the execute stage until ready_o is seen.
REQ-008 annul_i  input  1  cancel request from pipeline flush.
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}; the remainder feeds HI and the quotient feeds LO at write-back.
REQ-010 ready_o  output  1  1 = result_o is valid.

Function
REQ-011 The block SHALL implement four states: FREE, BYZERO, ON and END.
REQ-012 FREE, with start_i=1 and annul_i=0: divisor==0 SHALL transition to BYZERO; otherwise the block SHALL latch the operands, clear the iteration counter and transition to ON.
REQ-013 FREE, with start_i=0 or annul_i=1: the block SHALL remain in FREE, with ready_o=0 and result_o=0.
REQ-014 In signed mode, each negative operand SHALL be replaced by its two's-complement magnitude before iteration; in unsigned mode, operands SHALL be used unchanged.
REQ-015 ON: each edge SHALL perform one restoring shift-subtract step, producing one quotient bit MSB-first, and SHALL increment the counter; 32 steps SHALL be required.
REQ-016 ON with counter==32: the block SHALL apply sign correction, register result_o, set ready_o=1 and transition to END.
REQ-017 Sign correction (signed mode only): the quotient SHALL be negated iff the operand signs differ, and the remainder SHALL be negated iff the dividend is negative.
REQ-018 Overflow case 0x80000000 / 0xFFFFFFFF (signed) SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-019 Accepting edge to ready_o=1 SHALL take exactly 34 edges for nonzero divisors, independent of operand values.
REQ-020 BYZERO: the next edge SHALL transition to END with result_o=0 and ready_o=1, giving a latency of 2 edges.
REQ-021 ON with annul_i=1: the block SHALL transition to FREE on that edge, set ready_o=0 and result_o=0, and produce no result.
REQ-022 annul_i in BYZERO or END SHALL have no effect.
REQ-023 END: the block SHALL hold result_o and ready_o=1 while start_i=1.
REQ-024 END with start_i=0: the block SHALL transition to FREE, clearing ready_o and result_o on that edge.
REQ-025 Operand input changes after the accepting edge SHALL NOT affect the result in progress.
REQ-026 A new division SHALL be accepted only from FREE, so the minimum spacing between back-to-back operations is one FREE cycle.

Reset
REQ-027 rst=1 SHALL force the state to FREE, the counter to 0, ready_o to 0 and result_o to 0 on the next edge, overriding all other inputs.
REQ-028 rst asserted in any state, including mid-ON, SHALL abort the operation with no result produced.
REQ-029 After rst is released, the first start_i=1 SHALL be accepted normally.

Verification
REQ-030 Unsigned: 100 / 7, start held -> ready_o=1 exactly 34 edges after acceptance, result_o=0x00000002_0000000E.
REQ-031 Signed: 0xFFFFFFF9 / 0x00000002 (-7 / 2) -> result_o=0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3).
REQ-032 Signed: 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000; the same operands unsigned -> result_o=0x80000000_00000000.
REQ-033 Divide by zero: 5 / 0 -> ready_o=1 2 edges after acceptance, result_o=0; ready_o stays 1 until start_i drops, then returns to 0 with the block in FREE.
REQ-034 Annul: annul_i pulsed on the 10th ON edge -> ready_o never asserts, FREE is reached; a following 9 / 3 -> result_o=0x00000000_00000003 after 34 edges.
REQ-035 Reset mid-operation: rst on the 20th ON edge -> ready_o=0 and result_o=0 next edge; a subsequent 0xFFFFFFFF / 0x10 unsigned -> result_o=0x0000000F_0FFFFFFF.
